// File: rtl/neuron_pkg.sv
// Shared neuron datapath widths, types and activation range limits.
package neuron_pkg;

  localparam int unsigned ACC_W  = 17;
  localparam int unsigned DATA_W = 8;

  typedef logic signed [ACC_W-1:0]  acc_t;
  typedef logic signed [DATA_W-1:0] data_t;

  localparam data_t DATA_MAX = data_t'(127);
  localparam data_t DATA_MIN = data_t'(-128);

endpackage

// File: rtl/pipe_reg.sv
// One valid/ready register slice: loads whenever empty or being drained.
module pipe_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready_c,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  // Slot is free when empty or when its current word leaves this cycle.
  assign in_ready_c = !out_valid || out_ready;

  // Slot register; data only updates with a real word to save toggles.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready_c) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/neuron_requant.sv
// Streaming requantizer: round-half-up shift, 8-bit saturation, optional ReLU.
module neuron_requant
  import neuron_pkg::*;
#(
  parameter int unsigned IN_W    = ACC_W,
  parameter int unsigned OUT_W   = DATA_W,
  parameter int unsigned SHIFT   = 8,
  parameter int unsigned RELU_EN = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sat,
  input  logic             clr_count,
  output logic [CNT_W-1:0] sat_count
);

  // One guard bit keeps the rounding add from overflowing.
  localparam int unsigned R_W = IN_W + 1;
  // Half an output LSB; shifting left then right yields 0 when SHIFT is 0.
  localparam logic signed [R_W-1:0] RND = (R_W'(1) << SHIFT) >> 1;
  localparam int MAX_I = (1 << (OUT_W - 1)) - 1;
  localparam int MIN_I = -MAX_I - 1;
  localparam logic signed [R_W-1:0] R_MAX = R_W'(MAX_I);
  localparam logic signed [R_W-1:0] R_MIN = R_W'(MIN_I);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic signed [R_W-1:0] in_ext;
  logic signed [R_W-1:0] sum;
  logic signed [R_W-1:0] r_c;
  logic signed [R_W-1:0] s1_r;
  logic                  s1_valid;
  logic                  s2_load;
  logic [OUT_W-1:0]      q_c;
  logic                  sat_c;
  logic [OUT_W:0]        s2_word;

  // Stage 1 arithmetic: sign-extend, add rounding constant, arithmetic shift.
  assign in_ext = {in_data[IN_W-1], in_data};
  assign sum    = in_ext + RND;
  assign r_c    = sum >>> SHIFT;

  pipe_reg #(.W(R_W)) u_s1 (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready_c (in_ready),
    .in_data    (r_c),
    .out_valid  (s1_valid),
    .out_ready  (s2_load),
    .out_data   (s1_r)
  );

  // Stage 2 arithmetic: clamp to the activation range, then optional ReLU.
  always_comb begin
    sat_c = 1'b0;
    q_c   = s1_r[OUT_W-1:0];
    if (s1_r > R_MAX) begin
      q_c   = OUT_W'(MAX_I);
      sat_c = 1'b1;
    end else if (s1_r < R_MIN) begin
      q_c   = OUT_W'(MIN_I);
      sat_c = 1'b1;
    end
    if (RELU_EN != 0 && q_c[OUT_W-1]) begin
      q_c = '0;
    end
  end

  pipe_reg #(.W(OUT_W + 1)) u_s2 (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (s1_valid),
    .in_ready_c (s2_load),
    .in_data    ({sat_c, q_c}),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (s2_word)
  );

  assign out_sat  = s2_word[OUT_W];
  assign out_data = s2_word[OUT_W-1:0];

  // Saturation event counter: clear wins, sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst || clr_count) begin
      sat_count <= '0;
    end else if (out_valid && out_ready && out_sat && sat_count != CNT_MAX) begin
      sat_count <= sat_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_neuron_requant.sv
// Scoreboard bench: two instances (ReLU on / off) share the same stimulus.
module tb_neuron_requant;
  import neuron_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        clr_count = 1'b0;
  logic [16:0] in_data = '0;

  logic        in_ready, out_valid, out_sat;
  logic [7:0]  out_data;
  logic [15:0] sat_count;
  logic        in_ready_nr, out_valid_nr, out_sat_nr;
  logic [7:0]  out_data_nr;
  logic [15:0] sat_count_nr;

  always #5 clk = ~clk;

  neuron_requant #(.RELU_EN(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sat(out_sat), .clr_count(clr_count),
    .sat_count(sat_count)
  );

  neuron_requant #(.RELU_EN(0)) dut_nr (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_nr),
    .in_data(in_data), .out_valid(out_valid_nr), .out_ready(out_ready),
    .out_data(out_data_nr), .out_sat(out_sat_nr), .clr_count(clr_count),
    .sat_count(sat_count_nr)
  );

  typedef struct {
    data_t d;
    logic  s;
    data_t dn;
    logic  sn;
    int    cyc;
    bit    chk;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   popped = 0;
  int   last_pop = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare every output transfer against the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_out: got %0d expected no word", int'($signed(out_data)));
      end else begin
        mon_e = q.pop_front();
        check("out_data", int'($signed(out_data)), int'(mon_e.d));
        check("out_sat", int'(out_sat), int'(mon_e.s));
        check("nr_valid", int'(out_valid_nr), 1);
        check("nr_data", int'($signed(out_data_nr)), int'(mon_e.dn));
        check("nr_sat", int'(out_sat_nr), int'(mon_e.sn));
        if (mon_e.chk) check("latency", cyc - mon_e.cyc, 2);
        popped++;
        last_pop = cyc;
      end
    end
  end

  // Offer one word; push its expectation when the DUT takes it.
  task automatic send(input int v, input int d, input bit s, input int dn,
                      input bit sn, input bit chk);
    exp_t e;
    bit   got = 1'b0;
    in_valid = 1'b1;
    in_data  = 17'(v);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        e.d = data_t'(d); e.s = s; e.dn = data_t'(dn); e.sn = sn;
        e.cyc = cyc; e.chk = chk;
        q.push_back(e);
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 for input %0d", v);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Wait until every expected word has come out, then settle past the edge.
  task automatic drain(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (q.size() == 0) break;
      @(negedge clk);
    end
    if (q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
      q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   base, rel, rem;
    logic [7:0] hold;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_in_ready_nr", int'(in_ready_nr), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_sat", int'(out_sat), 0);
    check("rst_sat_count", int'(sat_count), 0);
    @(posedge clk);
    #1;

    // Rounding, half-up, with latency check
    send(384, 2, 0, 2, 0, 1);
    send(383, 1, 0, 1, 0, 1);
    send(128, 1, 0, 1, 0, 1);
    send(127, 0, 0, 0, 0, 1);
    drain(50);

    // Positive saturation
    send(40000, 127, 1, 127, 1, 0);
    drain(50);
    check("sat_count_1", int'(sat_count), 1);
    send(32767, 127, 1, 127, 1, 0);
    drain(50);
    check("sat_count_2", int'(sat_count), 2);

    // Negative path: ReLU instance gives 0, plain instance keeps the sign
    send(-384, 0, 0, -1, 0, 0);
    send(-65536, 0, 1, -128, 1, 0);
    drain(50);
    check("sat_count_3", int'(sat_count), 3);

    // Backpressure mid-stream
    base = popped;
    fork
      begin
        for (int k = 1; k <= 10; k++) send(k * 256, k, 0, k, 0, 0);
      end
      begin
        for (int i = 0; i < 100; i++) begin
          if (popped >= base + 3) break;
          @(negedge clk);
        end
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        hold = out_data;
        check("stall_in_ready", int'(in_ready), 0);
        repeat (4) begin
          @(negedge clk);
          check("stall_out_valid", int'(out_valid), 1);
          check("stall_out_data", int'(out_data), int'(hold));
          check("stall_in_ready", int'(in_ready), 0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        rel = cyc;
        rem = 10 - (popped - base);
        for (int i = 0; i < 100; i++) begin
          if (popped >= base + 10) break;
          @(negedge clk);
        end
        check("bp_delivered", popped - base, 10);
        check("bp_no_gap", last_pop - rel, rem - 1);
      end
    join
    drain(50);

    // Counter stickiness at 2^16-1
    @(posedge clk);
    #1 clr_count = 1'b1;
    @(posedge clk);
    #1 clr_count = 1'b0;
    check("clr_idle", int'(sat_count), 0);
    for (int i = 0; i < 65540; i++) send(40000, 127, 1, 127, 1, 0);
    drain(100);
    check("sat_sticky", int'(sat_count), 65535);
    check("sat_sticky_nr", int'(sat_count_nr), 65535);

    // Clear coinciding with a saturated transfer
    send(40000, 127, 1, 127, 1, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin
        clr_count = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1 clr_count = 1'b0;
    check("clr_wins", int'(sat_count), 0);
    drain(50);

    // Reset with two words in flight
    send(40000, 127, 1, 127, 1, 0);
    drain(50);
    check("pre_rst_count", int'(sat_count), 1);
    out_ready = 1'b0;
    send(40000, 127, 1, 127, 1, 0);
    send(512, 2, 0, 2, 0, 0);
    base = popped;
    rst = 1'b1;
    q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_sat_count", int'(sat_count), 0);
    check("mid_rst_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("lost_words", popped - base, 0);
    @(posedge clk);
    #1;
    send(-256, 0, 0, -1, 0, 1);
    drain(50);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/neuron_requant.md
Name: neuron_requant

Overview:
Streaming requantizer for the neuron datapath: the inverse of the 8-bit-to-16-bit sign-extend-and-accumulate path. It takes 17-bit signed accumulator totals and returns 8-bit signed activations. For each input it does a rounding arithmetic right shift, saturates to 8 bits and applies an optional ReLU. The block is a 2-stage valid/ready pipeline with full backpressure and a saturation event counter. It sits between the accumulator output and the next layer's 8-bit input.

Parameters:
IN_W, 17, input accumulator width (signed).
OUT_W, 8, output activation width (signed).
SHIFT, 8, fixed right-shift amount; legal range 0..IN_W-1.
RELU_EN, 1, 1 = negative results forced to 0 after saturation.
CNT_W, 16, saturation counter width.

Ports:
clk  in  1  clock, all logic on rising edge.
rst  in  1  reset; synchronous, active-high.
in_valid  in  1  input word present.
in_ready  out  1  block can accept input this cycle.
in_data  in  IN_W  signed accumulator total.
out_valid  out  1  output word present.
out_ready  in  1  downstream accepts output this cycle.
out_data  out  OUT_W  signed requantized activation.
out_sat  out  1  out_data was range-clamped (travels with out_data).
clr_count  in  1  synchronous clear of sat_count.
sat_count  out  CNT_W  number of saturated words transferred, sticky at max.

Behaviour:
- Reset (rst=1 at a clock edge):
  - Both stage valids, out_data, out_sat and sat_count go to 0.
  - in_ready=1 in the first cycle after reset.
  - Any data in flight during reset is discarded.
- Transfers: input when in_valid&&in_ready; output when out_valid&&out_ready.
- Pipeline:
  - Stage 1 (s1) registers the rounded and shifted value.
  - Stage 2 (s2) registers the saturated/ReLU result, out_data and out_sat.
  - Stage advance rules: s2 loads when !s2_valid || out_ready; s1 loads when !s1_valid || s2 loads.
  - in_ready = !s1_valid || s2 loads (combinational).
- Latency and throughput:
  - With out_ready held high, a word accepted at edge N shows on out_data after edge N+2.
  - Throughput is 1 word/cycle.
- Backpressure: while out_valid&&!out_ready, out_data and out_sat hold stable. Nothing is dropped or duplicated.
- Arithmetic (stage 1):
  - Work in IN_W+1 bits so the rounding add cannot overflow.
  - r = (sext(in_data) + (SHIFT>0 ? 2^(SHIFT-1) : 0)) >>> SHIFT, arithmetic shift.
  - This is round-half-up (toward +inf).
- Arithmetic (stage 2):
  - If r > 2^(OUT_W-1)-1: out = 127, out_sat=1.
  - If r < -2^(OUT_W-1): out = -128, out_sat=1.
  - Otherwise out = r, out_sat=0.
  - Then, if RELU_EN and out<0: out=0. out_sat keeps its range-clamp value; ReLU alone never sets out_sat.
- Counter:
  - sat_count increments on an output transfer with out_sat=1.
  - It holds at 2^CNT_W-1 (no wrap).
  - clr_count wins over a simultaneous increment; the result is 0.
- Simultaneous accept and emit in the same cycle is legal and required for full throughput.

Decomposition:
- Shared package neuron_pkg holds:
  - ACC_W=17, DATA_W=8.
  - typedefs acc_t (logic signed [ACC_W-1:0]) and data_t (logic signed [DATA_W-1:0]).
  - DATA_MAX=127, DATA_MIN=-128.
  These are shared with the adder/accumulator path.
- One natural sub-module: pipe_reg, a parameterized-width valid/ready register slice, instantiated twice (s1, s2).
- The shift, saturate and ReLU logic stays inline in neuron_requant.

Test Plan:
- Rounding, SHIFT=8, RELU_EN=1, out_ready=1: in 384, 383, 128, 127 → out 2, 1, 1, 0. Each appears 2 cycles after acceptance; out_sat=0.
- Positive saturation: in 40000 → out 127, out_sat=1, sat_count=1. Then in 32767 → out 127, out_sat=1, sat_count=2.
- Negative path, RELU_EN=0: in -384 → -1; in -65536 → -128 with out_sat=1.
  Same inputs with RELU_EN=1 → 0, 0; out_sat=0 then 1.
- Backpressure:
  - Stream 10 words back-to-back.
  - Hold out_ready=0 for 5 cycles mid-stream: in_ready drops after the 2 buffered words, and out_data stays stable.
  - Release: all 10 words are delivered in order, with no gaps while out_ready=1.
- Counter edges:
  - Preload near max via 2^16 saturated words: sat_count sticks at 65535.
  - Assert clr_count in the same cycle as a saturated transfer: sat_count becomes 0.
- Reset mid-stream: assert rst for 1 cycle with 2 words in flight. Next cycle out_valid=0, sat_count=0 and in_ready=1; the lost words never appear.
